// File: rtl/debug_snapshot_pkg.sv
// ============================================================================
//  Module      : debug_snapshot_pkg
//  Description : Shared constants and FSM state type for the debug snapshot
//                block. The CKSUM state exists only when DBG_CHECKSUM_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package debug_snapshot_pkg;

    localparam int DBG_NWORDS  = 32;
    localparam int DBG_ADDR_W  = 5;
    localparam int DBG_IDX_W   = 6;
    localparam int DBG_DATA_W  = 32;
    localparam int DBG_STATE_W = 2;

    // Index reported for the checksum word, one past the last data word
    localparam logic [DBG_IDX_W-1:0]  DBG_CKSUM_IDX = 6'd32;
    localparam logic [DBG_ADDR_W-1:0] DBG_LAST_ADDR = 5'd31;
    localparam logic [DBG_ADDR_W-1:0] DBG_ADDR_ONE  = 5'd1;

`ifdef DBG_CHECKSUM_EN
    typedef enum logic [DBG_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_STREAM = 2'd2,
        ST_CKSUM  = 2'd3
    } dbg_state_e;
`else
    typedef enum logic [DBG_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_STREAM = 2'd2
    } dbg_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/dbg_snap_ram.sv
// ============================================================================
//  Module      : dbg_snap_ram
//  Description : 32x32 snapshot storage, one synchronous write port and one
//                asynchronous read port. No reset: contents survive rstn.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_snap_ram
    import debug_snapshot_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DBG_ADDR_W-1:0] i_waddr,
    input  logic [DBG_DATA_W-1:0] i_wdata,
    input  logic [DBG_ADDR_W-1:0] i_raddr,
    output logic [DBG_DATA_W-1:0] o_rdata
);

    logic [DBG_DATA_W-1:0] r_mem [DBG_NWORDS];

    // Write one sampled word per cycle while the sweep is running
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/debug_snapshot.sv
// ============================================================================
//  Module      : debug_snapshot
//  Description : Sweeps the 32 debug-mux addresses into a snapshot RAM while
//                optionally freezing the CPU, then streams the words out over
//                a valid/ready interface. Defining DBG_CHECKSUM_EN appends an
//                XOR checksum word (idx 32) to the stream.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_snapshot
    import debug_snapshot_pkg::*;
#(
    parameter bit FREEZE_CPU = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  capture_req,
    output logic [DBG_ADDR_W-1:0] Debug_addr,
    input  logic [DBG_DATA_W-1:0] Test_signal,
    output logic                  cpu_freeze,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DBG_DATA_W-1:0] out_data,
    output logic [DBG_IDX_W-1:0]  out_idx,
    output logic                  out_last,
    output logic                  done
);

    dbg_state_e            r_state;
    logic [DBG_ADDR_W-1:0] r_sweep_cnt;
    logic [DBG_ADDR_W-1:0] r_idx;
    logic                  r_done;
    logic [DBG_DATA_W-1:0] w_rd_data;
    logic                  w_in_sweep;
    logic                  w_in_stream;

    assign w_in_sweep  = (r_state == ST_SWEEP);
    assign w_in_stream = (r_state == ST_STREAM);

    dbg_snap_ram u_ram (
        .clk     (clk),
        .i_we    (w_in_sweep),
        .i_waddr (r_sweep_cnt),
        .i_wdata (Test_signal),
        .i_raddr (r_idx),
        .o_rdata (w_rd_data)
    );

    // Control FSM: request -> 32-cycle sweep -> handshaked stream -> done
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_sweep_cnt <= '0;
            r_idx       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture_req) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_cnt <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_sweep_cnt <= r_sweep_cnt + DBG_ADDR_ONE;
                    if (r_sweep_cnt == DBG_LAST_ADDR) begin
                        r_state <= ST_STREAM;
                        r_idx   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        if (r_idx == DBG_LAST_ADDR) begin
`ifdef DBG_CHECKSUM_EN
                            r_state <= ST_CKSUM;
`else
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_idx <= r_idx + DBG_ADDR_ONE;
                        end
                    end
                end
`ifdef DBG_CHECKSUM_EN
                ST_CKSUM: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DBG_CHECKSUM_EN
    logic [DBG_DATA_W-1:0] r_cksum;

    // XOR accumulator: cleared when a sweep starts, folds in every sample
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cksum <= '0;
        end else if (r_state == ST_IDLE && capture_req) begin
            r_cksum <= '0;
        end else if (w_in_sweep) begin
            r_cksum <= r_cksum ^ Test_signal;
        end
    end
`endif

    assign Debug_addr = w_in_sweep ? r_sweep_cnt : '0;
    assign cpu_freeze = FREEZE_CPU && w_in_sweep;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

    // Stream port is a pure function of state, so it holds while stalled
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (w_in_stream) begin
            out_valid = 1'b1;
            out_data  = w_rd_data;
            out_idx   = {1'b0, r_idx};
`ifndef DBG_CHECKSUM_EN
            out_last  = (r_idx == DBG_LAST_ADDR);
`endif
        end
`ifdef DBG_CHECKSUM_EN
        if (r_state == ST_CKSUM) begin
            out_valid = 1'b1;
            out_data  = r_cksum;
            out_idx   = DBG_CKSUM_IDX;
            out_last  = 1'b1;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_snapshot.sv
// ============================================================================
//  Module      : tb_debug_snapshot
//  Description : Self-checking bench for debug_snapshot. A table-driven debug
//                mux feeds two instances (FREEZE_CPU=1 and 0); expected streams
//                come from the table contents and their XOR.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_snapshot;

`ifdef DBG_CHECKSUM_EN
    localparam int NW = 33;
`else
    localparam int NW = 32;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        capture_req;
    logic        out_ready;

    logic [4:0]  Debug_addr,  Debug_addr2;
    logic [31:0] Test_signal, Test_signal2;
    logic        cpu_freeze,  cpu_freeze2;
    logic        busy,        busy2;
    logic        out_valid,   out_valid2;
    logic [31:0] out_data,    out_data2;
    logic [5:0]  out_idx,     out_idx2;
    logic        out_last,    out_last2;
    logic        done,        done2;

    logic [31:0] mux_tbl [32];
    logic [31:0] exp_w   [NW];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign Test_signal  = mux_tbl[Debug_addr];
    assign Test_signal2 = mux_tbl[Debug_addr2];

    debug_snapshot #(.FREEZE_CPU(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .capture_req(capture_req),
        .Debug_addr(Debug_addr), .Test_signal(Test_signal),
        .cpu_freeze(cpu_freeze), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .done(done)
    );

    debug_snapshot #(.FREEZE_CPU(1'b0)) u_dut_nofrz (
        .clk(clk), .rstn(rstn), .capture_req(capture_req),
        .Debug_addr(Debug_addr2), .Test_signal(Test_signal2),
        .cpu_freeze(cpu_freeze2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_idx(out_idx2), .out_last(out_last2),
        .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0: 0xA0000000+addr, 1: random, 2: all 0x1, 3: addr
    task automatic fill_tbl(input int mode);
        for (int a = 0; a < 32; a++) begin
            case (mode)
                0:       mux_tbl[a] = 32'hA000_0000 + a;
                1:       mux_tbl[a] = $urandom;
                2:       mux_tbl[a] = 32'h1;
                default: mux_tbl[a] = a;
            endcase
        end
    endtask

    // Reference: stream is the table in address order, plus XOR when enabled
    task automatic build_exp();
        logic [31:0] x;
        x = '0;
        for (int a = 0; a < 32; a++) begin
            exp_w[a] = mux_tbl[a];
            x = x ^ mux_tbl[a];
        end
        if (NW == 33) exp_w[NW-1] = x;
    endtask

    task automatic pulse_capture();
        @(negedge clk);
        capture_req = 1'b1;
        @(negedge clk);
        capture_req = 1'b0;
    endtask

    // Called at the negedge of sweep cycle 0
    task automatic collect_sweep();
        int k;
        int nfrz;
        k = 0;
        nfrz = 0;
        while (!out_valid && k < 40) begin
            if (k < 32) chk("sweep_addr", Debug_addr, k);
            nfrz += int'(cpu_freeze);
            chk("nofrz_freeze", cpu_freeze2, 0);
            @(negedge clk);
            k++;
        end
        chk("sweep_len", k, 32);
        chk("freeze_cycles", nfrz, 32);
    endtask

    // rmode 0: always ready, 1: random ready, 2: 3-cycle stall at idx 5
    task automatic collect_stream(input int rmode);
        int  i;
        int  cyc;
        int  stall;
        logic rdy;
        i = 0;
        cyc = 0;
        stall = 0;
        while (i < NW && cyc < 400) begin
            chk("valid", out_valid, 1);
            chk("data", out_data, exp_w[i]);
            chk("idx", out_idx, i);
            chk("last", out_last, (i == NW-1));
            chk("nofrz_data", out_data2, exp_w[i]);
            chk("done_early", done, 0);
            chk("freeze_stream", cpu_freeze, 0);
            if (rmode == 0) rdy = 1'b1;
            else if (rmode == 1) rdy = ($urandom_range(0, 3) != 0);
            else if (i == 5 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else rdy = 1'b1;
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++;
        end
        chk("stream_count", i, NW);
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
        chk("nofrz_done", done2, 1);
        @(negedge clk);
        chk("done_once", done, 0);
    endtask

    task automatic run_capture(input int tmode, input int rmode);
        fill_tbl(tmode);
        build_exp();
        pulse_capture();
        collect_sweep();
        collect_stream(rmode);
    endtask

    initial begin
        rstn        = 1'b0;
        capture_req = 1'b0;
        out_ready   = 1'b0;
        fill_tbl(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_freeze", cpu_freeze, 0);
        chk("rst_addr", Debug_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;

        // Basic capture, ready held high
        run_capture(0, 0);
        // Stall at idx 5 for 3 cycles
        run_capture(0, 2);
        // Random data with random back-pressure
        for (int r = 0; r < 3; r++) run_capture(1, 1);

        // capture_req held: second sweep starts on the edge after done
        fill_tbl(1);
        build_exp();
        @(negedge clk);
        capture_req = 1'b1;
        @(negedge clk);
        collect_sweep();
        collect_stream(0);
        chk("rearm_busy", busy, 1);
        chk("rearm_freeze", cpu_freeze, 1);
        capture_req = 1'b0;
        collect_sweep();
        collect_stream(0);

        // Reset at sweep cycle 10
        fill_tbl(0);
        build_exp();
        pulse_capture();
        repeat (10) @(negedge clk);
        chk("pre_rst_addr", Debug_addr, 10);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_freeze", cpu_freeze, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", Debug_addr, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_no_done", done, 0);
        run_capture(0, 0);

        // Checksum-oriented patterns (plain stream when the macro is absent)
        run_capture(2, 1);
        run_capture(3, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_snapshot.md
DEBUG_SNAPSHOT -- requirements
Module: debug_snapshot

Interface
REQ-001 Parameter FREEZE_CPU, default 1: when 1, cpu_freeze is driven during the sweep; when 0, cpu_freeze is tied 0.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 capture_req  input  1  level/pulse request to take one snapshot.
REQ-005 Debug_addr  output  5  sample address to the debug mux.
REQ-006 Test_signal  input  32  sampled word from the debug mux, combinational in Debug_addr.
REQ-007 cpu_freeze  output  1  pipeline hold request (PC/stage enables forced off by the CPU top).
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 out_valid  output  1  stream word valid.
REQ-010 out_ready  input  1  stream consumer ready.
REQ-011 out_data  output  32  stream word.
REQ-012 out_idx  output  6  index of the stream word (0..31 data, 32 checksum).
REQ-013 out_last  output  1  marks the final stream word.
REQ-014 done  output  1  one-cycle pulse after the final stream transfer.

Function
REQ-015 FSM states IDLE, SWEEP, STREAM, plus CKSUM when DBG_CHECKSUM_EN is defined.
REQ-016 IDLE -> SWEEP on a clock edge where capture_req=1; the sweep counter loads 0.
REQ-017 In SWEEP, Debug_addr = sweep counter; on each edge, Test_signal is written to snapshot entry [counter] and the counter increments; the sweep lasts exactly 32 cycles.
REQ-018 SWEEP -> STREAM on the edge that writes entry 31; the stream index loads 0.
REQ-019 cpu_freeze = FREEZE_CPU && (state==SWEEP), so the CPU is frozen for all 32 sample cycles.
REQ-020 Outside SWEEP, Debug_addr = 0.
REQ-021 In STREAM, out_valid=1, out_data=snapshot[idx], and out_idx=idx; a transfer occurs on an edge with out_valid && out_ready.
REQ-022 While out_valid && !out_ready, out_data, out_idx and out_last hold stable.
REQ-023 A transfer at idx 31 goes to IDLE (no checksum) or to CKSUM (checksum). Otherwise idx increments.
REQ-024 out_last=1 only on the final word: idx 31 without checksum, or the CKSUM word with it.
REQ-025 done pulses for exactly one cycle, in the cycle after the final transfer (the first IDLE cycle).
REQ-026 capture_req is ignored while busy; a request held across the return to IDLE starts a new sweep on the next edge.
REQ-027 The snapshot storage is 32x32, holds its contents in IDLE, and is overwritten only during SWEEP.
REQ-028 Minimum end-to-end time with out_ready held high: 1 request edge, 32 sweep cycles, then 32 (or 33) stream cycles.

Reset
REQ-029 When rstn=0 at an edge: state=IDLE, counters=0, Debug_addr=0, cpu_freeze=0, busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0.
REQ-030 Reset mid-SWEEP or mid-STREAM aborts immediately with no done pulse, and cpu_freeze drops in the first reset cycle.
REQ-031 Snapshot contents are not cleared by reset.

Configuration
REQ-032 Macro DBG_CHECKSUM_EN, when defined: an XOR accumulator is cleared on SWEEP entry and XORs each captured word; CKSUM presents the accumulator as the stream word with out_idx=32 and out_last=1, under the same handshake rules; 33 words are streamed.
REQ-033 When DBG_CHECKSUM_EN is not defined: no accumulator and no CKSUM state; exactly 32 words are streamed, and out_idx never exceeds 31.

Structure
REQ-034 The shared debug package holds the FSM state enum, the constants DBG_NWORDS=32, DBG_ADDR_W=5 and DBG_IDX_W=6, and the checksum index constant 32.
REQ-035 One sub-module, dbg_snap_ram: a 32x32 storage with one synchronous write port and one asynchronous read port; the FSM, counters and handshake live in debug_snapshot.

Verification
REQ-036 Mux model returns Test_signal = 0xA0000000 + Debug_addr; pulse capture_req; ready held high -> cpu_freeze is high for exactly 32 cycles, the stream is 0xA0000000..0xA000001F with idx 0..31, and done pulses once.
REQ-037 Same stimulus, with out_ready deasserted for 3 cycles at idx 5 -> out_data stays 0xA0000005 and idx stays 5 for all 3 cycles; no word is duplicated or skipped.
REQ-038 capture_req held high for 100 cycles -> the first snapshot streams completely, and a second SWEEP starts on the edge after done.
REQ-039 rstn=0 asserted at sweep cycle 10 -> next cycle: IDLE, cpu_freeze=0, out_valid=0, no done pulse; a new capture afterwards streams all 32 words correctly.
REQ-040 With DBG_CHECKSUM_EN, all words = 0x1 -> the 33rd word is 0x00000000 with idx 32 and out_last=1; with mux = addr, the checksum is 0x00000000. Without the macro, out_last is set at idx 31.
REQ-041 FREEZE_CPU=0 -> cpu_freeze stays 0 throughout the sweep, and the data stream is otherwise identical to REQ-036.
